fifo_write_arbiter: RTL and testbench



---
 rtl/fifo_write_arbiter_if.sv | 22 ++
 rtl/fifo_write_arbiter.sv | 71 +++++++
 tb/tb_fifo_write_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: requester bundle and FIFO write-side signals shared by the arbiter and its clients
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            grant;
    logic                          busy;
    logic                          full;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         data_in;
    modport master (
        input  req, req_data, full,
        output req_ack, grant, busy, w_en, data_in
    );
    modport slave (
        output req, req_data, full,
        input  req_ack, grant, busy, w_en, data_in
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input logic                 wclk,
    input logic                 wrst,
    fifo_write_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, sel, nxt;
    logic [BW-1:0] burst_q, burst_d;
    logic          found, busy, w_en;
    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req[(int'(ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                sel   = IW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end
    assign nxt  = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign busy = (state_q == GRANT);
    assign w_en = busy && bus.req[owner_q] && !bus.full;
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = GRANT;
                owner_d = sel;
                burst_d = '0;
            end
        end else if (w_en) begin
            burst_d = burst_q + 1'b1;
            if (burst_d == BW'(MAX_BURST)) begin
                state_d = IDLE;
                ptr_d   = nxt;
            end
        end else if (!bus.req[owner_q]) begin
            state_d = IDLE;
            ptr_d   = nxt;
        end
    end
    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
        end
    end
    assign bus.w_en    = w_en;
    assign bus.busy    = busy;
    assign bus.grant   = busy ? NUM_REQ'(1) << owner_q : '0;
    assign bus.req_ack = w_en ? NUM_REQ'(1) << owner_q : '0;
    assign bus.data_in = w_en ? bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: vector table, directed corner sequences and random traffic against a reference model
module tb_fifo_write_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam logic [31:0] D = 32'hA3A2A1A0;
    logic wclk = 1'b0;
    logic wrst = 1'b0;
    always #5 wclk = ~wclk;
    fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
    fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .wclk(wclk),
        .wrst(wrst),
        .bus (bus)
    );
    typedef struct {
        logic [3:0] req;
        logic [7:0] d0;
        logic [3:0] grant;
        logic       wen;
        logic [7:0] dout;
    } vec_t;
    vec_t tbl[10];
    int n_chk  = 0;
    int n_fail = 0;
    int own    = -1;
    int rr     = 0;
    int cnt    = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_check();
        logic [3:0] eg;
        logic       ew;
        logic [7:0] ed;
        eg = (own >= 0) ? 4'(1 << own) : 4'b0;
        ew = (own >= 0) ? (bus.req[own] && !bus.full) : 1'b0;
        ed = ew ? bus.req_data[own*DW +: DW] : 8'h00;
        chk("m_grant", 32'(bus.grant), 32'(eg));
        chk("m_busy", 32'(bus.busy), 32'(own >= 0));
        chk("m_wen", 32'(bus.w_en), 32'(ew));
        chk("m_ack", 32'(bus.req_ack), ew ? 32'(eg) : 32'h0);
        chk("m_data", 32'(bus.data_in), 32'(ed));
    endtask
    task automatic model_edge();
        if (own < 0) begin
            for (int k = 0; k < N; k++) begin
                if (bus.req[(rr + k) % N]) begin
                    own = (rr + k) % N;
                    cnt = 0;
                    break;
                end
            end
        end else if (bus.req[own] && !bus.full) begin
            cnt++;
            if (cnt == MB) begin
                rr  = (own + 1) % N;
                own = -1;
            end
        end else if (!bus.req[own]) begin
            rr  = (own + 1) % N;
            own = -1;
        end
    endtask
    task automatic cyc(input logic [3:0] r, input logic f, input logic [31:0] d);
        bus.req      = r;
        bus.full     = f;
        bus.req_data = d;
        #3;
        model_check();
    endtask
    task automatic adv();
        @(posedge wclk);
        model_edge();
        #1;
    endtask
    task automatic zero_chk(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant), 32'h0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
        chk({tag, "_wen"}, 32'(bus.w_en), 32'h0);
        chk({tag, "_ack"}, 32'(bus.req_ack), 32'h0);
        chk({tag, "_data"}, 32'(bus.data_in), 32'h0);
    endtask
    task automatic do_reset();
        wrst = 1'b0;
        own  = -1;
        rr   = 0;
        cnt  = 0;
        #2;
        zero_chk("rst");
        @(posedge wclk);
        #1;
        wrst = 1'b1;
    endtask
    initial begin
        logic [3:0] r;
        tbl[0] = '{4'b0001, 8'h10, 4'b0000, 1'b0, 8'h00};
        tbl[1] = '{4'b0001, 8'h10, 4'b0001, 1'b1, 8'h10};
        tbl[2] = '{4'b0001, 8'h11, 4'b0001, 1'b1, 8'h11};
        tbl[3] = '{4'b0001, 8'h12, 4'b0001, 1'b1, 8'h12};
        tbl[4] = '{4'b0001, 8'h13, 4'b0001, 1'b1, 8'h13};
        tbl[5] = '{4'b0001, 8'h14, 4'b0000, 1'b0, 8'h00};
        tbl[6] = '{4'b0001, 8'h14, 4'b0001, 1'b1, 8'h14};
        tbl[7] = '{4'b0001, 8'h15, 4'b0001, 1'b1, 8'h15};
        tbl[8] = '{4'b0000, 8'h15, 4'b0001, 1'b0, 8'h00};
        tbl[9] = '{4'b0000, 8'h15, 4'b0000, 1'b0, 8'h00};
        bus.req      = 4'b1111;
        bus.full     = 1'b0;
        bus.req_data = D;
        wrst         = 1'b0;
        #1;
        zero_chk("rst_async");
        @(posedge wclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            #3;
            zero_chk("rst_hold");
            @(posedge wclk);
            #1;
        end
        wrst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].req, 1'b0, {24'hA3A2A1, tbl[i].d0});
            chk("tbl_grant", 32'(bus.grant), 32'(tbl[i].grant));
            chk("tbl_wen", 32'(bus.w_en), 32'(tbl[i].wen));
            chk("tbl_data", 32'(bus.data_in), 32'(tbl[i].dout));
            adv();
        end
        do_reset();
        for (int g = 0; g < 5; g++) begin
            cyc(4'b1111, 1'b0, D);
            chk("rr_idle", 32'(bus.grant), 32'h0);
            adv();
            for (int w = 0; w < MB; w++) begin
                cyc(4'b1111, 1'b0, D);
                chk("rr_grant", 32'(bus.grant), 32'(1 << (g % N)));
                chk("rr_wen", 32'(bus.w_en), 32'h1);
                adv();
            end
        end
        do_reset();
        cyc(4'b0100, 1'b0, D);
        adv();
        cyc(4'b0100, 1'b0, D);
        chk("full_first", 32'(bus.data_in), 32'hA2);
        adv();
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0100, 1'b1, D);
            chk("full_wen", 32'(bus.w_en), 32'h0);
            chk("full_ack", 32'(bus.req_ack), 32'h0);
            chk("full_grant", 32'(bus.grant), 32'h4);
            adv();
        end
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0100, 1'b0, D);
            chk("full_resume", 32'(bus.w_en), 32'h1);
            adv();
        end
        cyc(4'b0100, 1'b0, D);
        chk("full_release", 32'(bus.grant), 32'h0);
        adv();
        do_reset();
        cyc(4'b0010, 1'b0, D);
        adv();
        for (int i = 0; i < 2; i++) begin
            cyc(4'b0010, 1'b0, D);
            chk("drop_wen", 32'(bus.w_en), 32'h1);
            adv();
        end
        cyc(4'b1001, 1'b0, D);
        chk("drop_hold", 32'(bus.grant), 32'h2);
        chk("drop_nowen", 32'(bus.w_en), 32'h0);
        adv();
        cyc(4'b1001, 1'b0, D);
        chk("drop_idle", 32'(bus.grant), 32'h0);
        adv();
        for (int i = 0; i < MB; i++) begin
            cyc(4'b1001, 1'b0, D);
            chk("drop_next", 32'(bus.grant), 32'h8);
            chk("drop_data", 32'(bus.data_in), 32'hA3);
            adv();
        end
        cyc(4'b1001, 1'b0, D);
        chk("drop_bubble", 32'(bus.grant), 32'h0);
        adv();
        cyc(4'b1001, 1'b0, D);
        chk("drop_wrap", 32'(bus.grant), 32'h1);
        adv();
        do_reset();
        cyc(4'b1000, 1'b0, D);
        adv();
        for (int i = 0; i < 2; i++) begin
            cyc(4'b1000, 1'b0, D);
            adv();
        end
        cyc(4'b1000, 1'b0, D);
        chk("mid_wen", 32'(bus.w_en), 32'h1);
        #1;
        wrst = 1'b0;
        own  = -1;
        rr   = 0;
        cnt  = 0;
        #1;
        zero_chk("mid_rst");
        @(posedge wclk);
        #1;
        wrst = 1'b1;
        cyc(4'b1010, 1'b0, D);
        chk("mid_idle", 32'(bus.grant), 32'h0);
        adv();
        cyc(4'b1010, 1'b0, D);
        chk("mid_regrant", 32'(bus.grant), 32'h2);
        adv();
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            cyc(r, $urandom_range(3) == 0, $urandom());
            adv();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
